// File: rtl/fft_burst_sched_if.sv
// Channel/engine signal bundle for fft_burst_sched; the scheduler side is `master`.
// FFT_SCHED_WATCHDOG_EN adds the err_tmo/tmo_state watchdog status signals.
interface fft_burst_sched_if #(
    parameter int LEN_WIDTH = 4,
    parameter int CNT_WIDTH = 16
);
    logic [1:0]           req;
    logic [LEN_WIDTH-1:0] ch0_len;
    logic [LEN_WIDTH-1:0] ch1_len;
    logic [1:0]           ch_inv;
    logic [1:0]           grant;
    logic                 eng_start;
    logic [LEN_WIDTH-1:0] eng_len;
    logic                 eng_inv;
    logic                 in_last_hs;
    logic                 fft_cdone;
    logic                 out_last_hs;
    logic                 busy;
    logic                 frame_done;
    logic                 done_ch;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic                 err_spur;
`ifdef FFT_SCHED_WATCHDOG_EN
    logic                 err_tmo;
    logic [1:0]           tmo_state;
`endif

    modport master (
        input  req, ch0_len, ch1_len, ch_inv, in_last_hs, fft_cdone, out_last_hs,
        output grant, eng_start, eng_len, eng_inv, busy, frame_done, done_ch,
               frame_cnt, err_spur
`ifdef FFT_SCHED_WATCHDOG_EN
        , output err_tmo, tmo_state
`endif
    );

    modport slave (
        output req, ch0_len, ch1_len, ch_inv, in_last_hs, fft_cdone, out_last_hs,
        input  grant, eng_start, eng_len, eng_inv, busy, frame_done, done_ch,
               frame_cnt, err_spur
`ifdef FFT_SCHED_WATCHDOG_EN
        , input err_tmo, tmo_state
`endif
    );
endinterface

// File: rtl/fft_burst_sched.sv
// Round-robin scheduler sharing one burst FFT engine between two channels (load/calc/unload).
// Optional per-phase watchdog enabled by defining FFT_SCHED_WATCHDOG_EN.
module fft_burst_sched #(
    parameter int LEN_WIDTH = 4,
    parameter int CNT_WIDTH = 16
`ifdef FFT_SCHED_WATCHDOG_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input logic                clk,
    input logic                rst_n,
    fft_burst_sched_if.master  bus
);
    // Encoding doubles as the tmo_state report value.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CALC   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 rr_q, rr_d;
    logic                 served_q, served_d;
    logic [1:0]           grant_q, grant_d;
    logic                 eng_start_q, eng_start_d;
    logic [LEN_WIDTH-1:0] eng_len_q, eng_len_d;
    logic                 eng_inv_q, eng_inv_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 done_ch_q, done_ch_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                 err_spur_q, err_spur_d;
    logic                 win;
    logic                 spur;

`ifdef FFT_SCHED_WATCHDOG_EN
    localparam int PH_W = $clog2(TIMEOUT_CYCLES);
    logic [PH_W-1:0] phase_q, phase_d;
    logic            err_tmo_q, err_tmo_d;
    logic [1:0]      tmo_state_q, tmo_state_d;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d      = state_q;
        rr_d         = rr_q;
        served_d     = served_q;
        grant_d      = grant_q;
        eng_start_d  = 1'b0;
        eng_len_d    = eng_len_q;
        eng_inv_d    = eng_inv_q;
        frame_done_d = 1'b0;
        done_ch_d    = done_ch_q;
        frame_cnt_d  = frame_cnt_q;
        err_spur_d   = err_spur_q;

        win  = bus.req[rr_q] ? rr_q : ~rr_q;
        spur = (bus.fft_cdone && state_q != CALC) || (bus.out_last_hs && state_q != UNLOAD);
        if (spur) err_spur_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = LOAD;
                    grant_d     = win ? 2'b10 : 2'b01;
                    eng_start_d = 1'b1;
                    eng_len_d   = win ? bus.ch1_len : bus.ch0_len;
                    eng_inv_d   = bus.ch_inv[win];
                    served_d    = win;
                    rr_d        = ~win;
                end
            end
            LOAD: begin
                // A last-sample strobe coinciding with the start pulse belongs to no frame yet.
                if (bus.in_last_hs && !eng_start_q) begin
                    grant_d = 2'b00;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (bus.fft_cdone) state_d = UNLOAD;
            end
            UNLOAD: begin
                if (bus.out_last_hs) begin
                    frame_done_d = 1'b1;
                    done_ch_d    = served_q;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FFT_SCHED_WATCHDOG_EN
        err_tmo_d   = 1'b0;
        tmo_state_d = tmo_state_q;
        // Expiry abandons the frame outright; it never counts as completed.
        if (state_q != IDLE && phase_q == PH_W'(TIMEOUT_CYCLES - 1)) begin
            state_d      = IDLE;
            grant_d      = 2'b00;
            frame_done_d = 1'b0;
            done_ch_d    = done_ch_q;
            frame_cnt_d  = frame_cnt_q;
            err_tmo_d    = 1'b1;
            tmo_state_d  = state_q;
        end
        if (state_d != state_q)
            phase_d = '0;
        else if (state_q != IDLE)
            phase_d = phase_q + 1'b1;
        else
            phase_d = phase_q;
`endif

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            served_q     <= 1'b0;
            grant_q      <= 2'b00;
            eng_start_q  <= 1'b0;
            eng_len_q    <= '0;
            eng_inv_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            done_ch_q    <= 1'b0;
            frame_cnt_q  <= '0;
            err_spur_q   <= 1'b0;
`ifdef FFT_SCHED_WATCHDOG_EN
            phase_q      <= '0;
            err_tmo_q    <= 1'b0;
            tmo_state_q  <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            served_q     <= served_d;
            grant_q      <= grant_d;
            eng_start_q  <= eng_start_d;
            eng_len_q    <= eng_len_d;
            eng_inv_q    <= eng_inv_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            done_ch_q    <= done_ch_d;
            frame_cnt_q  <= frame_cnt_d;
            err_spur_q   <= err_spur_d;
`ifdef FFT_SCHED_WATCHDOG_EN
            phase_q      <= phase_d;
            err_tmo_q    <= err_tmo_d;
            tmo_state_q  <= tmo_state_d;
`endif
        end
    end

    assign bus.grant      = grant_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_len    = eng_len_q;
    assign bus.eng_inv    = eng_inv_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.done_ch    = done_ch_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.err_spur   = err_spur_q;
`ifdef FFT_SCHED_WATCHDOG_EN
    assign bus.err_tmo    = err_tmo_q;
    assign bus.tmo_state  = tmo_state_q;
`endif
endmodule

// File: tb/tb_fft_burst_sched.sv
// Self-checking bench for fft_burst_sched: vector table, randomized frames vs. a
// transaction-level model, and hand-written corner sequences (watchdog under FFT_SCHED_WATCHDOG_EN).
module tb_fft_burst_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    int   prio = 0;

    always #5 clk = ~clk;

    fft_burst_sched_if #(.LEN_WIDTH(4), .CNT_WIDTH(16)) bus ();

    fft_burst_sched #(
        .LEN_WIDTH(4),
        .CNT_WIDTH(16)
`ifdef FFT_SCHED_WATCHDOG_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0] req;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [1:0] inv;
        int         exp_ch;
        logic [3:0] exp_len;
        logic       exp_inv;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in an IDLE cycle and check the grant that follows one edge later.
    task automatic start_frame(input logic [1:0] req, input logic [3:0] l0, input logic [3:0] l1,
                               input logic [1:0] inv, input int ch, input logic [3:0] elen,
                               input logic einv);
        bus.req = req; bus.ch0_len = l0; bus.ch1_len = l1; bus.ch_inv = inv;
        tick();
        check("grant", {30'd0, bus.grant}, ch ? 2 : 1);
        check("eng_start", bus.eng_start, 1);
        check("eng_len", bus.eng_len, elen);
        check("eng_inv", bus.eng_inv, einv);
        check("busy_load", bus.busy, 1);
        check("frame_done_low", bus.frame_done, 0);
    endtask

    // Walk the granted frame through LOAD/CALC/UNLOAD; ends in the frame_done cycle.
    task automatic finish_frame(input int ch, input logic [3:0] elen, input logic einv,
                                input int lw, input int cw, input int uw, input bit early);
        if (early) begin
            bus.in_last_hs = 1'b1;
            tick();
            bus.in_last_hs = 1'b0;
            check("early_last_ignored", {30'd0, bus.grant}, ch ? 2 : 1);
        end else begin
            tick();
        end
        check("eng_start_pulse", bus.eng_start, 0);
        for (int i = 0; i < lw; i++) begin
            bus.req = 2'($urandom); bus.ch0_len = 4'($urandom);
            bus.ch1_len = 4'($urandom); bus.ch_inv = 2'($urandom);
            tick();
            check("grant_held", {30'd0, bus.grant}, ch ? 2 : 1);
        end
        bus.in_last_hs = 1'b1;
        tick();
        bus.in_last_hs = 1'b0;
        check("grant_drop", {30'd0, bus.grant}, 0);
        check("busy_calc", bus.busy, 1);
        check("eng_len_held", bus.eng_len, elen);
        check("eng_inv_held", bus.eng_inv, einv);
        repeat (cw) tick();
        bus.fft_cdone = 1'b1;
        tick();
        bus.fft_cdone = 1'b0;
        check("busy_unload", bus.busy, 1);
        repeat (uw) tick();
        bus.out_last_hs = 1'b1;
        tick();
        bus.out_last_hs = 1'b0;
        exp_cnt = (exp_cnt + 1) % 65536;
        check("frame_done", bus.frame_done, 1);
        check("done_ch", bus.done_ch, ch);
        check("frame_cnt", bus.frame_cnt, exp_cnt);
        check("busy_idle", bus.busy, 0);
        check("eng_len_idle", bus.eng_len, elen);
    endtask

    task automatic go_idle();
        bus.req = 2'b00;
        tick();
        check("idle_busy", bus.busy, 0);
        check("idle_done_low", bus.frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req = 2'b00; bus.ch0_len = '0; bus.ch1_len = '0; bus.ch_inv = 2'b00;
        bus.in_last_hs = 1'b0; bus.fft_cdone = 1'b0; bus.out_last_hs = 1'b0;

        // Channel order follows round-robin with channel 0 first after reset.
        vecs[0] = '{2'b01, 4'd8,  4'd3,  2'b00, 0, 4'd8,  1'b0};
        vecs[1] = '{2'b11, 4'd8,  4'd3,  2'b10, 1, 4'd3,  1'b1};
        vecs[2] = '{2'b11, 4'd8,  4'd3,  2'b10, 0, 4'd8,  1'b0};
        vecs[3] = '{2'b11, 4'd8,  4'd3,  2'b10, 1, 4'd3,  1'b1};
        vecs[4] = '{2'b10, 4'd2,  4'd7,  2'b01, 1, 4'd7,  1'b0};
        vecs[5] = '{2'b10, 4'd2,  4'd9,  2'b11, 1, 4'd9,  1'b1};
        vecs[6] = '{2'b11, 4'd15, 4'd0,  2'b01, 0, 4'd15, 1'b1};
        vecs[7] = '{2'b01, 4'd0,  4'd6,  2'b00, 0, 4'd0,  1'b0};
        vecs[8] = '{2'b11, 4'd4,  4'd12, 2'b10, 1, 4'd12, 1'b1};

        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", {30'd0, bus.grant}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_eng_len", bus.eng_len, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);
        check("rst_err_spur", bus.err_spur, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("idle_no_req", bus.busy, 0);

        for (int v = 0; v < 9; v++) begin
            start_frame(vecs[v].req, vecs[v].l0, vecs[v].l1, vecs[v].inv,
                        vecs[v].exp_ch, vecs[v].exp_len, vecs[v].exp_inv);
            finish_frame(vecs[v].exp_ch, vecs[v].exp_len, vecs[v].exp_inv, 2, 4, 3, 1'b0);
        end
        prio = 1 - vecs[8].exp_ch;

        for (int k = 0; k < 24; k++) begin
            logic [1:0] r, iv;
            logic [3:0] a, b;
            int c;
            r  = 2'($urandom_range(1, 3));
            a  = 4'($urandom);
            b  = 4'($urandom);
            iv = 2'($urandom);
            c  = r[prio] ? prio : 1 - prio;
            prio = 1 - c;
            start_frame(r, a, b, iv, c, c ? b : a, iv[c]);
            finish_frame(c, c ? b : a, iv[c], $urandom_range(0, 5), $urandom_range(0, 8),
                         $urandom_range(0, 8), $urandom_range(0, 3) == 0);
        end
        check("no_spur_in_legal_traffic", bus.err_spur, 0);

        // Length change during LOAD must wait for the next arbitration.
        start_frame(2'b01, 4'd8, 4'd1, 2'b00, 0, 4'd8, 1'b0);
        bus.ch0_len = 4'd5;
        finish_frame(0, 4'd8, 1'b0, 0, 2, 2, 1'b0);
        start_frame(2'b01, 4'd5, 4'd1, 2'b00, 0, 4'd5, 1'b0);
        finish_frame(0, 4'd5, 1'b0, 1, 1, 1, 1'b0);
        go_idle();
        check("len_held_idle", bus.eng_len, 5);

        bus.fft_cdone = 1'b1;
        tick();
        bus.fft_cdone = 1'b0;
        check("spur_cdone_idle", bus.err_spur, 1);
        check("spur_busy", bus.busy, 0);
        check("spur_grant", {30'd0, bus.grant}, 0);
        start_frame(2'b10, 4'd3, 4'd11, 2'b10, 1, 4'd11, 1'b1);
        finish_frame(1, 4'd11, 1'b1, 2, 2, 2, 1'b0);
        check("spur_sticky", bus.err_spur, 1);
        go_idle();

        // Reset while in CALC after a channel-0 frame moved priority to channel 1.
        start_frame(2'b01, 4'd6, 4'd2, 2'b00, 0, 4'd6, 1'b0);
        bus.req = 2'b00;
        tick();
        bus.in_last_hs = 1'b1;
        tick();
        bus.in_last_hs = 1'b0;
        check("pre_reset_calc", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_rst_grant", {30'd0, bus.grant}, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_eng_len", bus.eng_len, 0);
        check("mid_rst_frame_cnt", bus.frame_cnt, 0);
        check("mid_rst_err_spur", bus.err_spur, 0);
        check("mid_rst_done_ch", bus.done_ch, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        start_frame(2'b11, 4'd9, 4'd4, 2'b01, 0, 4'd9, 1'b1);
        bus.req = 2'b00;
        tick();
        bus.out_last_hs = 1'b1;
        tick();
        bus.out_last_hs = 1'b0;
        check("spur_last_in_load", bus.err_spur, 1);
        check("load_kept", {30'd0, bus.grant}, 1);
        bus.in_last_hs = 1'b1; bus.fft_cdone = 1'b1;
        tick();
        bus.in_last_hs = 1'b0; bus.fft_cdone = 1'b0;
        check("both_to_calc_grant", {30'd0, bus.grant}, 0);
        check("both_to_calc_busy", bus.busy, 1);
        bus.fft_cdone = 1'b1;
        tick();
        bus.fft_cdone = 1'b0;
        bus.out_last_hs = 1'b1;
        tick();
        bus.out_last_hs = 1'b0;
        exp_cnt = 1;
        check("post_rst_done", bus.frame_done, 1);
        check("post_rst_cnt", bus.frame_cnt, exp_cnt);
        go_idle();

`ifdef FFT_SCHED_WATCHDOG_EN
        start_frame(2'b01, 4'd7, 4'd2, 2'b00, 0, 4'd7, 1'b0);
        bus.req = 2'b00;
        tick();
        bus.in_last_hs = 1'b1;
        tick();
        bus.in_last_hs = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("tmo_not_yet", bus.err_tmo, 0);
        end
        tick();
        check("tmo_pulse", bus.err_tmo, 1);
        check("tmo_state", bus.tmo_state, 2);
        check("tmo_busy", bus.busy, 0);
        check("tmo_grant", {30'd0, bus.grant}, 0);
        check("tmo_frame_cnt", bus.frame_cnt, exp_cnt);
        tick();
        check("tmo_one_cycle", bus.err_tmo, 0);
        check("tmo_state_hold", bus.tmo_state, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_burst_sched.md
Name: fft_burst_sched

Overview:
- Schedules one shared burst FFT/IFFT engine (load → compute → unload) between two requesting channels.
- Arbitrates channels round-robin and latches the winner's transform length and direction onto the engine configuration.
- Issues the engine start pulse, then tracks frame-input last, engine compute-done and output-stream last.
- Sits between the channel front-ends and the engine core, whose output stage presents the result stream.

Parameters:
- LEN_WIDTH, 4, width of transform-length code (dft_length) per channel.
- CNT_WIDTH, 16, width of completed-frame counter.
- TIMEOUT_CYCLES, 4096, watchdog limit per phase (optional feature only).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  per-channel frame request, level.
- ch0_len  in  LEN_WIDTH  channel 0 length code.
- ch1_len  in  LEN_WIDTH  channel 1 length code.
- ch_inv  in  2  per-channel direction, 1 = IFFT.
- grant  out  2  one-hot input-path grant.
- eng_start  out  1  one-cycle engine start pulse.
- eng_len  out  LEN_WIDTH  latched length to engine (dft_length).
- eng_inv  out  1  latched direction to engine.
- in_last_hs  in  1  last input sample accepted by engine (valid & ready & last).
- fft_cdone  in  1  engine compute-done pulse.
- out_last_hs  in  1  output last handshake (m_axi_last & m_axi_ready).
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at end of unload.
- done_ch  out  1  channel of the completed frame, valid with frame_done.
- frame_cnt  out  CNT_WIDTH  completed frames, wraps.
- err_spur  out  1  sticky; fft_cdone outside CALC or out_last_hs outside UNLOAD.

Behaviour:
- Reset values:
  - grant = 0, eng_start = 0, eng_len = 0, eng_inv = 0, busy = 0, frame_done = 0, done_ch = 0, frame_cnt = 0, err_spur = 0.
  - State = IDLE; round-robin pointer rr = 0, meaning channel 0 has priority.
- States: IDLE, LOAD, CALC, UNLOAD. All outputs are registered.
- IDLE, when req != 0 at cycle N:
  - Winner is rr's channel if requesting, else the other channel.
  - At N+1: grant[w] = 1, eng_start = 1 for exactly one cycle, eng_len/eng_inv loaded from winner's config, state = LOAD, rr = ~w.
- LOAD:
  - grant held regardless of req changes.
  - Config changes on ch*_len/ch_inv are ignored until the next arbitration.
  - in_last_hs → next cycle: grant = 0, state = CALC.
- CALC: fft_cdone → state = UNLOAD.
- UNLOAD: out_last_hs → next cycle:
  - frame_done = 1 for one cycle, done_ch = served channel, frame_cnt += 1 (wraps to 0), state = IDLE.
- Idle cycles:
  - Minimum one IDLE cycle between frames; re-arbitration occurs in that IDLE cycle.
  - A channel holding req continuously alternates with the other channel when both request.
- eng_len/eng_inv hold their value from grant until the next grant, including through IDLE.
- Spurious events:
  - fft_cdone in any state other than CALC, or out_last_hs in any state other than UNLOAD, → err_spur = 1 next cycle.
  - State is unchanged. err_spur stays set until reset.
- Simultaneous events:
  - in_last_hs in the same cycle as eng_start is legal only from the next cycle onward; in_last_hs in the eng_start cycle is ignored.
  - fft_cdone arriving in the same cycle as in_last_hs → err_spur is set and the state still goes to CALC. The engine contract forbids this.
- Reset mid-frame: asynchronous return to the reset values above; engine is reset by the same rst_n.

Optional Feature:
- Macro FFT_SCHED_WATCHDOG_EN.
- Defined:
  - Adds a phase counter, cleared on every state change, incrementing in LOAD/CALC/UNLOAD.
  - When the counter reaches TIMEOUT_CYCLES-1 → next cycle: grant = 0, state = IDLE, frame_cnt unchanged.
  - Adds output err_tmo (1 bit), a one-cycle pulse on expiry. Adds output tmo_state (2 bits, encoding LOAD=1, CALC=2, UNLOAD=3), which holds the phase that expired.
- Not defined: no counter, no err_tmo/tmo_state ports; a stalled phase waits indefinitely.

Test Plan:
1. Single frame: req = 01, ch0_len = 4'd8, ch_inv = 00 → at N+1 grant = 01, eng_start pulse, eng_len = 8; in_last_hs at +20 → grant = 00; fft_cdone at +60; out_last_hs at +80 → frame_done = 1, done_ch = 0, frame_cnt = 1.
2. Contention: req = 11 held for 4 frames → grant sequence 01, 10, 01, 10; eng_inv follows ch_inv = 10 as 0, 1, 0, 1.
3. Config change in LOAD: ch0_len changes from 8 to 5 while grant = 01 → eng_len stays 8 for the whole frame, becomes 5 at the next ch0 grant.
4. Spurious done: fft_cdone in IDLE → err_spur = 1 next cycle, busy = 0, state unchanged; a following normal frame completes correctly.
5. Reset mid-CALC: rst_n low for 2 cycles → all outputs at reset values immediately; next req = 10 grants channel 1 (rr back to 0, channel 0 not requesting).
6. Watchdog (macro defined, TIMEOUT_CYCLES = 16): no fft_cdone in CALC → err_tmo pulse 16 cycles after CALC entry, tmo_state = 2, state = IDLE, frame_cnt unchanged.
